// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu issue path.
//   alu_op_e     : 3-bit ALU opcode (0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL, 5-7 reserved)
//   alu_cmd_t    : one buffered command (op/A/B)
//   seq_state_e  : issue FSM states
//   is_nop_class : true for opcodes that pulse start but never produce a response
package tinyalu_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpAdd  = 3'd1,
    OpAnd  = 3'd2,
    OpXor  = 3'd3,
    OpMul  = 3'd4,
    OpRsv5 = 3'd5,
    OpRsv6 = 3'd6,
    OpRsv7 = 3'd7
  } alu_op_e;

  localparam alu_op_e OP_NOP       = OpNop;
  localparam alu_op_e OP_RSV_FIRST = OpRsv5;

  typedef struct packed {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StNop
  } seq_state_e;

  // Reserved opcodes are treated like NOP: tinyalu never answers them.
  function automatic logic is_nop_class(alu_op_e op);
    return (op == OP_NOP) || (op >= OP_RSV_FIRST);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t with first-word fall-through read.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write request/data (ignored when full)
//   pop, rdata   : read request (ignored when empty), head entry
//   empty        : no entries held
//   ready        : registered !full, low during and one edge after reset
module alu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  alu_cmd_t wdata,
  input  logic     pop,
  output alu_cmd_t rdata,
  output logic     empty,
  output logic     ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  alu_cmd_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              ready_q;
  logic              full, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign ready   = ready_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of tinyalu: buffers commands, drives start/op/A/B with one
// operation in flight, and holds each result on a valid/ready response port.
// Optional watchdog: define ALU_SEQ_WATCHDOG_EN to abort RUN after WD_LIMIT cycles.
//   clk, reset_n                         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/a/b       : command input port
//   start/op/A/B, done/result            : tinyalu pin interface
//   rsp_valid/rsp_ready/rsp_result/rsp_op: response output port
//   busy                                 : FSM not idle or commands queued
//   timeout_err                          : sticky watchdog abort flag
module alu_cmd_sequencer
  import tinyalu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WD_LIMIT   = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        start,
  output logic [2:0]  op,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic        done,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        busy,
  output logic        timeout_err
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_bad_wd_limit
    $error("WD_LIMIT must fit the 8-bit watchdog counter");
  end

  seq_state_e  state_q, state_d;
  logic        start_q, start_d;
  alu_op_e     op_q;
  logic [7:0]  a_q, b_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_result_q;
  alu_op_e     rsp_op_q;

  alu_cmd_t    fifo_wdata, fifo_rdata;
  logic        fifo_empty, fifo_ready, fifo_push, pop;
  logic        can_issue, done_take, rsp_set;

  assign fifo_wdata = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b};
  assign fifo_push  = cmd_valid && fifo_ready;

  alu_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .wdata  (fifo_wdata),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .ready  (fifo_ready)
  );

  // Issue only once the response slot is free or being drained this edge, so a
  // held response is never overwritten.
  assign can_issue = !fifo_empty && (!rsp_valid_q || rsp_ready);
  // done only counts once start has actually been presented to the ALU.
  assign done_take = (state_q == StRun) && start_q && done;

  logic wd_hit;

`ifdef ALU_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(WD_LIMIT - 1);

  logic [7:0] wd_q;
  logic       timeout_q;

  assign wd_hit      = (state_q == StRun) && (wd_q == WD_LAST);
  assign timeout_err = timeout_q;

  // Zero outside RUN, so it starts from 0 on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (state_q == StRun) ? wd_q + 8'd1 : 8'd0;
      if (wd_hit && !done_take) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    pop     = 1'b0;
    rsp_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_d = 1'b0;
        if (can_issue) begin
          pop     = 1'b1;
          state_d = is_nop_class(fifo_rdata.op) ? StNop : StRun;
        end
      end
      StRun: begin
        start_d = 1'b1;
        if (done_take) begin
          start_d = 1'b0;
          rsp_set = 1'b1;
          state_d = StIdle;
        end else if (wd_hit) begin
          start_d = 1'b0;
          state_d = StIdle;
        end
      end
      StNop: begin
        // Single-cycle pulse: start rises on leaving NOP and falls in IDLE.
        start_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        start_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      op_q         <= OpNop;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= OpNop;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      if (pop) begin
        op_q <= fifo_rdata.op;
        a_q  <= fifo_rdata.a;
        b_q  <= fifo_rdata.b;
      end
      if (rsp_set) begin
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= result;
        rsp_op_q     <= op_q;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_ready  = fifo_ready;
  assign start      = start_q;
  assign op         = op_q;
  assign A          = a_q;
  assign B          = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. A behavioural tinyalu stub answers
// start pulses (1 cycle for ADD/AND/XOR, 3 cycles for MUL, nothing for NOP-class).
// Expected responses come from a queue of accepted commands and plain arithmetic.
// Define ALU_SEQ_WATCHDOG_EN to also exercise the watchdog.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  A, B;
  logic        done = 1'b0;
  logic [15:0] result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        busy;
  logic        timeout_err;

  alu_cmd_sequencer #(
    .FIFO_DEPTH(4),
    .WD_LIMIT  (15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .done       (done),
    .result     (result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] exp_q[$];  // {op, result} expected, in order
  logic [18:0] rcv_q[$];  // {op, result} accepted by the consumer
  int          nop_len_q[$];
  int          start_rises = 0;
  bit          hold_done = 1'b0;
  bit          rand_bp = 1'b0;

  function automatic bit is_nop(input logic [2:0] o);
    return (o == 3'd0) || (o >= 3'd5);
  endfunction

  function automatic logic [15:0] alu_ref(input logic [2:0] o, input logic [7:0] a,
                                          input logic [7:0] b);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // tinyalu stub driven from the DUT's pins.
  int alu_cnt = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      alu_cnt <= 0;
    end else if (alu_cnt != 0) begin
      if (alu_cnt == 1) done <= 1'b1;
      alu_cnt <= alu_cnt - 1;
    end else if (done) begin
      done <= 1'b0;
    end else if (start && !hold_done && !is_nop(op)) begin
      result <= alu_ref(op, A, B);
      if (op == 3'd4) alu_cnt <= 2;
      else            done    <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) rcv_q.push_back({rsp_op, rsp_result});
  end

  // Start pulse bookkeeping: count rises, record pulse widths of NOP-class ops.
  logic       start_prev = 1'b0;
  int         pulse_len = 0;
  logic [2:0] pulse_op = '0;
  always @(negedge clk) begin
    if (start) begin
      if (!start_prev) begin
        start_rises++;
        pulse_len = 0;
        pulse_op  = op;
      end
      pulse_len++;
    end else if (start_prev && is_nop(pulse_op)) begin
      nop_len_q.push_back(pulse_len);
    end
    start_prev = start;
  end

  task automatic push_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    cmd_op = o; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rand_bp) rsp_ready = 1'($urandom_range(0, 1));
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_accept: cmd_ready never seen, got 0 required 1 (op=%0d)", o);
    end else if (!is_nop(o)) begin
      exp_q.push_back({o, alu_ref(o, a, b)});
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && !start && !done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, start, op, A, B, rsp_valid, rsp_result, rsp_op, busy, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b st=%b op=%0d A=%h B=%h rv=%b rr=%h ro=%0d bz=%b to=%b required all 0",
               cmd_ready, start, op, A, B, rsp_valid, rsp_result, rsp_op, busy, timeout_err);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_edge: got rdy=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_add();
    int base = rcv_q.size();
    bit seen = 1'b0, ok;
    exp_q.delete();
    rsp_ready = 1'b0;
    push_cmd(3'd1, 8'h12, 8'h34);
    n_checks++;
    if (start !== 1'b0) begin
      n_fail++; $display("FAIL add_start_early: got %b required 0", start);
    end
    @(negedge clk);
    n_checks++;
    if (start !== 1'b0) begin
      n_fail++; $display("FAIL add_start_n1: got %b required 0", start);
    end
    @(negedge clk);
    n_checks++;
    if ({start, op, A, B} !== {1'b1, 3'd1, 8'h12, 8'h34}) begin
      n_fail++;
      $display("FAIL add_issue: got st=%b op=%0d A=%h B=%h required 1/1/12/34", start, op, A, B);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_op} !== {1'b1, 16'h0046, 3'd1}) begin
      n_fail++;
      $display("FAIL add_rsp: got v=%b res=%h op=%0d required 1/0046/1", rsp_valid, rsp_result, rsp_op);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_rsp_clear: got %b required 0", rsp_valid);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || rcv_q.size() - base !== 1 || rcv_q[base] !== {3'd1, 16'h0046}) begin
      n_fail++; $display("FAIL add_scoreboard: got %0d responses required 1", rcv_q.size() - base);
    end
  endtask

  task automatic test_mul_backpressure();
    int base = rcv_q.size();
    bit seen = 1'b0, ok;
    exp_q.delete();
    rsp_ready = 1'b0;
    push_cmd(3'd4, 8'hFF, 8'hFF);
    push_cmd(3'd3, 8'h0F, 8'hF0);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_op, start} !== {1'b1, 16'hFE01, 3'd4, 1'b0}) begin
        n_fail++;
        $display("FAIL mul_hold[%0d]: got v=%b res=%h op=%0d st=%b required 1/FE01/4/0",
                 i, rsp_valid, rsp_result, rsp_op, start);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (start) seen = 1'b1;
    end
    n_checks++;
    if ({start, op, A, B} !== {1'b1, 3'd3, 8'h0F, 8'hF0}) begin
      n_fail++;
      $display("FAIL xor_issue: got st=%b op=%0d A=%h B=%h required 1/3/0F/F0", start, op, A, B);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || rcv_q.size() - base !== exp_q.size()) begin
      n_fail++;
      $display("FAIL mul_count: got %0d responses required %0d", rcv_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rcv_q[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL mul_rsp[%0d]: got %h required %h", i, rcv_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_fill_fifo();
    int base = rcv_q.size();
    bit ok;
    exp_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(3'd1, 8'(i + 1), 8'(i * 3 + 7));
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL fill_full: got rdy=%b busy=%b required 0/1", cmd_ready, busy);
    end
    // Offer a sixth command while full; it must not be taken.
    cmd_op = 3'd1; cmd_a = 8'hEE; cmd_b = 8'hEE; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_still_full: got %b required 0", cmd_ready);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(ok);
    n_checks++;
    if (!ok || rcv_q.size() - base !== 5) begin
      n_fail++; $display("FAIL fill_count: got %0d responses required 5", rcv_q.size() - base);
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rcv_q[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL fill_rsp[%0d]: got %h required %h", i, rcv_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_nop_interleave();
    int base = rcv_q.size();
    int r0 = start_rises;
    int n0 = nop_len_q.size();
    bit ok;
    exp_q.delete();
    rsp_ready = 1'b1;
    push_cmd(3'd2, 8'hF0, 8'h3C);
    push_cmd(3'd0, 8'h11, 8'h22);
    push_cmd(3'd6, 8'h33, 8'h44);
    push_cmd(3'd2, 8'hAA, 8'h0F);
    wait_idle(ok);
    n_checks++;
    if (!ok || start_rises - r0 !== 4) begin
      n_fail++; $display("FAIL nop_starts: got %0d start pulses required 4", start_rises - r0);
    end
    n_checks++;
    if (nop_len_q.size() - n0 !== 2) begin
      n_fail++; $display("FAIL nop_pulses: got %0d required 2", nop_len_q.size() - n0);
    end else begin
      for (int i = n0; i < nop_len_q.size(); i++) begin
        n_checks++;
        if (nop_len_q[i] !== 1) begin
          n_fail++; $display("FAIL nop_width: got %0d cycles required 1", nop_len_q[i]);
        end
      end
    end
    n_checks++;
    if (rcv_q.size() - base !== 2) begin
      n_fail++; $display("FAIL nop_count: got %0d responses required 2", rcv_q.size() - base);
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rcv_q[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL nop_rsp[%0d]: got %h required %h", i, rcv_q[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int base;
    int hi = 0;
    bit seen = 1'b0;
    rsp_ready = 1'b1;
    push_cmd(3'd4, 8'h10, 8'h20);
    push_cmd(3'd1, 8'h01, 8'h01);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (start) seen = 1'b1;
      else @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({start, rsp_valid, busy, cmd_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_outputs: got st=%b rv=%b bz=%b rdy=%b required 0/0/0/0",
               start, rsp_valid, busy, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    base = rcv_q.size();
    repeat (2) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: got %b required 1", cmd_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (start || busy) hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 0 || rcv_q.size() !== base) begin
      n_fail++;
      $display("FAIL midrst_discard: got %0d active cycles, %0d responses required 0/0",
               hi, rcv_q.size() - base);
    end
  endtask

  task automatic test_random();
    int base = rcv_q.size();
    bit ok;
    exp_q.delete();
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      push_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) begin
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    rand_bp = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(ok);
    n_checks++;
    if (!ok || rcv_q.size() - base !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d responses required %0d", rcv_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rcv_q[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_rsp[%0d]: got %h required %h", i, rcv_q[base + i], exp_q[i]);
        end
      end
    end
`ifndef ALU_SEQ_WATCHDOG_EN
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL no_watchdog: got timeout_err=%b required 0", timeout_err);
    end
`endif
  endtask

`ifdef ALU_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int base = rcv_q.size();
    int hi = 0;
    bit seen = 1'b0, ok;
    rsp_ready = 1'b1;
    hold_done = 1'b1;
    push_cmd(3'd4, 8'hFF, 8'hFF);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (start) seen = 1'b1;
      else @(negedge clk);
    end
    for (int i = 0; i < 40 && start; i++) begin
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (start !== 1'b0 || timeout_err !== 1'b1 || rsp_valid !== 1'b0 || hi < 12 || hi > 16) begin
      n_fail++;
      $display("FAIL wd_abort: got st=%b to=%b rv=%b high=%0d required 0/1/0/12..16",
               start, timeout_err, rsp_valid, hi);
    end
    hold_done = 1'b0;
    exp_q.delete();
    push_cmd(3'd1, 8'h05, 8'h06);
    wait_idle(ok);
    n_checks++;
    if (!ok || rcv_q.size() - base !== 1 || rcv_q[base] !== {3'd1, 16'h000B} || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_recover: got %0d responses to=%b required 1 response 000B, to=1",
               rcv_q.size() - base, timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_mul_backpressure();
    test_fill_fifo();
    test_nop_interleave();
    test_reset_mid_op();
    test_random();
`ifdef ALU_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Synthesizable issue stage sitting directly upstream of tinyalu.
- Buffers ALU commands arriving on a valid/ready port and drives tinyalu's start/op/A/B pin protocol, one operation in flight.
- Captures done/result into a valid/ready response port for the downstream consumer.
- Replaces the pin-wiggling half of the bench driver when the ALU is embedded in a larger FPGA design.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- WD_LIMIT, 15, watchdog cycles in RUN before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  3  0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL, 5-7 reserved
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- start  out  1  to tinyalu start
- op  out  3  to tinyalu op
- A  out  8  to tinyalu A
- B  out  8  to tinyalu B
- done  in  1  from tinyalu done
- result  in  16  from tinyalu result
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  16  captured result
- rsp_op  out  3  opcode that produced it
- busy  out  1  FSM not IDLE, or FIFO non-empty
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: clk, reset_n; reset is asynchronous, active-low.
  - All outputs are 0, FIFO is empty, FSM is IDLE.
  - cmd_ready goes 1 the first clk edge after reset_n deasserts.
- Reset mid-operation: start drops immediately, and in-flight and buffered commands are discarded.
- Command port:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered.
  - When full, cmd_ready=0 and the push is ignored.
  - Push and pop in the same cycle are legal whenever not full; occupancy is unchanged.
- FSM states: IDLE, RUN, NOP.
  - IDLE: start=0. If FIFO non-empty and rsp_valid=0:
    - pop the head and register op/A/B;
    - set start=1 next cycle;
    - go to NOP if op is 0 or 5-7, else RUN.
  - IDLE also waits while rsp_valid=1. Back-pressure stalls issue; it never overwrites a response.
  - RUN: start, op, A and B stay stable until done=1 is sampled. Then:
    - rsp_result<=result, rsp_op<=op, rsp_valid<=1;
    - start<=0;
    - go to IDLE.
  - NOP: start is high for exactly one cycle, then go to IDLE. No response is produced.
- done while in IDLE or NOP is ignored.
- start is low for at least one cycle between consecutive operations.
  - Minimum issue spacing is 3 cycles for 1-cycle ops.
- Latency: a command pushed at edge N, FIFO previously empty, raises start at edge N+2. rsp_valid rises on the edge after done is sampled.
- Response port: rsp_valid holds, with data stable, until rsp_valid && rsp_ready; it clears on that edge.
- Only one op is ever in flight, so no response overflow is possible.
- A, B and result pass through unchanged; no width conversion.

Optional Feature:
- ALU_SEQ_WATCHDOG_EN defined:
  - An 8-bit counter clears on entry to RUN and increments each RUN cycle.
  - On reaching WD_LIMIT without done: start<=0, timeout_err<=1 (sticky until reset), FSM goes to IDLE, no response.
  - done arriving in the same cycle as the limit wins: normal response, no error.
- Undefined: no counter; timeout_err tied 0; RUN waits indefinitely.

Decomposition:
- tinyalu_pkg gains:
  - alu_op_e, a 3-bit enum;
  - alu_cmd_t, a struct of op/A/B;
  - constants for NOP and the reserved range.
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO of alu_cmd_t with full/empty, async active-low reset.
- FSM and response register stay in alu_cmd_sequencer.

Test Plan:
- Single ADD: push a=8'h12, b=8'h34 into an idle block.
  - start rises 2 cycles later with op=1.
  - Next cycle rsp_valid=1, rsp_result=16'h0046, rsp_op=1.
- MUL with back-pressure: a=8'hFF, b=8'hFF, rsp_ready=0 for 10 cycles.
  - rsp_result=16'hFE01 holds.
  - A queued XOR is not issued until the handshake completes.
- Fill FIFO: push 5 ADDs with rsp_ready=0.
  - cmd_ready=0 after the 4th is queued and 1st issued.
  - All 5 responses arrive in order once rsp_ready=1.
- NOP and op=6 interleaved between two ANDs.
  - Each NOP-class op gives a 1-cycle start pulse and no response.
  - Exactly 2 responses; done never seen after NOP.
- Reset during MUL RUN (reset_n low 1 cycle).
  - start, rsp_valid and busy go 0 immediately.
  - The queued command is gone and cmd_ready=1 after release.
- With ALU_SEQ_WATCHDOG_EN, hold done=0 on a MUL.
  - After 15 RUN cycles: start=0, timeout_err=1, no response.
  - The next ADD completes normally while timeout_err stays 1.
